// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment scan scheduler.
package disp_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam logic [3:0]  AN_OFF   = 4'b1111;

  typedef logic [3:0]  nibble_t;
  typedef logic [1:0]  digit_idx_t;
  typedef logic [15:0] disp_word_t;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  // Nibble of the display word that belongs to digit idx.
  function automatic nibble_t word_nibble(disp_word_t w, digit_idx_t idx);
    return w[{idx, 2'b00} +: 4];
  endfunction

  // Active-low one-hot anode pattern for digit idx.
  function automatic logic [3:0] an_for(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

  // Index of the most significant nonzero nibble; 0 for an all-zero word.
  function automatic digit_idx_t top_digit(disp_word_t w);
    digit_idx_t top;
    top = '0;
    for (int i = 1; i < int'(N_DIGITS); i++) begin
      if (w[4*i +: 4] != 4'h0) top = digit_idx_t'(i);
    end
    return top;
  endfunction

endpackage

// File: rtl/disp_load_buf.sv
// Single-entry pending buffer in front of the active display word.
// A promote strobe moves a held word into active; with bypass high an accepted
// word goes straight to active instead of waiting in the pending slot.
module disp_load_buf
  import disp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  disp_word_t data_i,
  output logic       ready_o,
  input  logic       promote_i,
  input  logic       bypass_i,
  output disp_word_t active_o,
  output disp_word_t active_d_o
);

  disp_word_t pend_q, pend_d;
  disp_word_t active_q, active_d;
  logic       ready_q, ready_d;   // high while the pending slot is empty
  logic       accept;

  assign accept = valid_i & ready_q;

  // Next pending/active state; promote needs a full slot, accept an empty one.
  always_comb begin
    pend_d   = pend_q;
    active_d = active_q;
    ready_d  = ready_q;
    if (!ready_q && promote_i) begin
      active_d = pend_q;
      ready_d  = 1'b1;
    end
    if (accept) begin
      if (bypass_i) begin
        active_d = data_i;
      end else begin
        pend_d  = data_i;
        ready_d = 1'b0;
      end
    end
  end

  // Buffer registers, synchronous reset discards any pending word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      active_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign ready_o    = ready_q;
  assign active_o   = active_q;
  assign active_d_o = active_d;

endmodule

// File: rtl/disp_scan_sched.sv
// Four-digit seven-segment scan scheduler: blank gap, then dwell per digit,
// with a double-buffered display word that only changes at frame boundaries.
// Optional build macro LEADING_ZERO_BLANK_EN keeps digits above the highest
// nonzero nibble dark (digit 0 always lit).
module disp_scan_sched #(
  parameter int unsigned DWELL_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned N_DIGITS     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        load_valid_i,
  input  logic [15:0] load_data_i,
  output logic        load_ready_o,
  output logic [1:0]  digit_sel_o,
  output logic [3:0]  digit_val_o,
  output logic [3:0]  an_o,
  output logic        frame_done_o
);

  import disp_pkg::*;

  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam digit_idx_t        LastDigit = digit_idx_t'(N_DIGITS - 1);

  scan_state_t       state_q, state_d;
  logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;
  logic [DwellW-1:0] dwell_cnt_q, dwell_cnt_d;
  digit_idx_t        sel_q, sel_d;
  nibble_t           val_q, val_d;
  logic [3:0]        an_q, an_d;
  logic              frame_done_q, frame_done_d;

  disp_word_t        active_q, active_d;
  logic              promote, bypass;
  logic [3:0]        show_an;

  // frame_done_q marks the boundary cycle; idle or disabling also flushes pending.
  assign promote = frame_done_q | (state_q == IDLE) | ~enable_i;
  assign bypass  = frame_done_q;

  disp_load_buf u_load_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (load_valid_i),
    .data_i     (load_data_i),
    .ready_o    (load_ready_o),
    .promote_i  (promote),
    .bypass_i   (bypass),
    .active_o   (active_q),
    .active_d_o (active_d)
  );

  // Anode pattern for the digit about to be shown.
`ifdef LEADING_ZERO_BLANK_EN
  assign show_an = (sel_q > top_digit(active_d)) ? AN_OFF : an_for(sel_q);
`else
  assign show_an = an_for(sel_q);
`endif

  // Scan FSM next state: blank gap then dwell for each digit, wrap at the last.
  always_comb begin
    state_d      = state_q;
    blank_cnt_d  = blank_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    sel_d        = sel_q;
    an_d         = an_q;
    frame_done_d = 1'b0;
    if (!enable_i) begin
      state_d     = IDLE;
      blank_cnt_d = '0;
      dwell_cnt_d = '0;
      sel_d       = '0;
      an_d        = AN_OFF;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = BLANK;
          sel_d       = '0;
          blank_cnt_d = '0;
          an_d        = AN_OFF;
        end
        BLANK: begin
          if (blank_cnt_q == BlankLast) begin
            state_d     = SHOW;
            blank_cnt_d = '0;
            dwell_cnt_d = '0;
            an_d        = show_an;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (dwell_cnt_q == DwellLast) begin
            state_d     = BLANK;
            dwell_cnt_d = '0;
            an_d        = AN_OFF;
            if (sel_q == LastDigit) begin
              sel_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Active only changes outside SHOW, so the nibble is steady while lit.
    val_d = word_nibble(active_d, sel_d);
  end

  // All scan state and outputs registered; synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      blank_cnt_q  <= '0;
      dwell_cnt_q  <= '0;
      sel_q        <= '0;
      val_q        <= '0;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_cnt_q  <= blank_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      sel_q        <= sel_d;
      val_q        <= val_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_sel_o  = sel_q;
  assign digit_val_o  = val_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_disp_scan_sched.sv
// Directed bench for disp_scan_sched with DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_disp_scan_sched;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, load_valid;
  logic [15:0] load_data;
  logic        load_ready, frame_done;
  logic [1:0]  digit_sel;
  logic [3:0]  digit_val, an;

  int cyc, total, bad;

  always #5 clk = ~clk;

  disp_scan_sched #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2),
    .N_DIGITS     (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .digit_sel_o  (digit_sel),
    .digit_val_o  (digit_val),
    .an_o         (an),
    .frame_done_o (frame_done)
  );

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [1:0] sel;
    logic [3:0] val;
    logic       fd;
    logic       rdy;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] e_an, input logic [1:0] e_sel,
                          input logic [3:0] e_val, input logic e_fd, input logic e_rdy);
    chk({nm, ".an"},    16'(an),         16'(e_an));
    chk({nm, ".sel"},   16'(digit_sel),  16'(e_sel));
    chk({nm, ".val"},   16'(digit_val),  16'(e_val));
    chk({nm, ".fd"},    16'(frame_done), 16'(e_fd));
    chk({nm, ".ready"}, 16'(load_ready), 16'(e_rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    // First two frames after enable; 1234 is accepted on edge 2.
    vecs[0]  = '{1,  4'hF, 2'd0, 4'h0, 1'b0, 1'b1};
    vecs[1]  = '{2,  4'hF, 2'd0, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{3,  4'hE, 2'd0, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{6,  4'hE, 2'd0, 4'h0, 1'b0, 1'b0};
    vecs[4]  = '{7,  4'hF, 2'd1, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{9,  Lzb ? 4'hF : 4'hD, 2'd1, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{15, Lzb ? 4'hF : 4'hB, 2'd2, 4'h0, 1'b0, 1'b0};
    vecs[7]  = '{21, Lzb ? 4'hF : 4'h7, 2'd3, 4'h0, 1'b0, 1'b0};
    vecs[8]  = '{24, Lzb ? 4'hF : 4'h7, 2'd3, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{25, 4'hF, 2'd0, 4'h0, 1'b1, 1'b0};
    vecs[10] = '{26, 4'hF, 2'd0, 4'h4, 1'b0, 1'b1};
    vecs[11] = '{27, 4'hE, 2'd0, 4'h4, 1'b0, 1'b1};
    vecs[12] = '{31, 4'hF, 2'd1, 4'h3, 1'b0, 1'b1};
    vecs[13] = '{33, 4'hD, 2'd1, 4'h3, 1'b0, 1'b1};
    vecs[14] = '{39, 4'hB, 2'd2, 4'h2, 1'b0, 1'b1};
    vecs[15] = '{45, 4'h7, 2'd3, 4'h1, 1'b0, 1'b1};
    vecs[16] = '{48, 4'h7, 2'd3, 4'h1, 1'b0, 1'b1};
    vecs[17] = '{49, 4'hF, 2'd0, 4'h4, 1'b1, 1'b1};
    vecs[18] = '{50, 4'hF, 2'd0, 4'h4, 1'b0, 1'b1};

    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = 16'h0;
    tick();
    tick();
    chk_outs("reset", 4'hF, 2'd0, 4'h0, 1'b0, 1'b1);

    rst = 1'b0;
    enable = 1'b1;
    cyc = 0;
    for (int i = 0; i < 19; i++) begin
      while (cyc < vecs[i].k) begin
        tick();
        load_valid = (cyc == 1);
        load_data  = 16'h1234;
      end
      chk_outs($sformatf("vec%0d", i), vecs[i].an, vecs[i].sel, vecs[i].val, vecs[i].fd,
               vecs[i].rdy);
    end

    // AAAA accepted mid-frame; BBBB held off until the boundary frees the slot.
    run_to(55);
    load_valid = 1'b1;
    load_data  = 16'hAAAA;
    tick();
    load_data = 16'hBBBB;
    ok = 1'b1;
    while (cyc < 73) begin
      if (load_ready) ok = 1'b0;
      tick();
    end
    chk("held.ready_low", 16'(ok), 16'd1);
    chk_outs("boundary73", 4'hF, 2'd0, 4'h4, 1'b1, 1'b0);
    tick();
    chk_outs("promote74", 4'hF, 2'd0, 4'hA, 1'b0, 1'b1);
    tick();
    load_valid = 1'b0;
    chk("bbbb.accept.ready", 16'(load_ready), 16'd0);
    run_to(76);
    chk_outs("aaaa.show", 4'hE, 2'd0, 4'hA, 1'b0, 1'b0);
    run_to(98);
    chk_outs("bbbb.promote", 4'hF, 2'd0, 4'hB, 1'b0, 1'b1);
    run_to(99);
    chk_outs("bbbb.show", 4'hE, 2'd0, 4'hB, 1'b0, 1'b1);

    // C0DE offered on the frame_done cycle bypasses the pending slot.
    run_to(121);
    chk_outs("boundary121", 4'hF, 2'd0, 4'hB, 1'b1, 1'b1);
    load_valid = 1'b1;
    load_data  = 16'hC0DE;
    tick();
    load_valid = 1'b0;
    chk_outs("bypass122", 4'hF, 2'd0, 4'hE, 1'b0, 1'b1);
    run_to(127);
    chk_outs("c0de.d1", 4'hF, 2'd1, 4'hD, 1'b0, 1'b1);
    run_to(133);
    chk_outs("c0de.d2", 4'hF, 2'd2, 4'h0, 1'b0, 1'b1);
    run_to(141);
    chk_outs("c0de.d3", 4'h7, 2'd3, 4'hC, 1'b0, 1'b1);
    run_to(145);
    chk_outs("boundary145", 4'hF, 2'd0, 4'hE, 1'b1, 1'b1);

    // Disable during digit 2 SHOW, then re-enable.
    run_to(160);
    chk_outs("d2.show", 4'hB, 2'd2, 4'h0, 1'b0, 1'b1);
    enable = 1'b0;
    tick();
    chk_outs("disabled", 4'hF, 2'd0, 4'hE, 1'b0, 1'b1);
    tick();
    chk("idle.an", 16'(an), 16'hF);
    enable = 1'b1;
    tick();
    chk("reen.blank0.an", 16'(an), 16'hF);
    tick();
    chk("reen.blank1.an", 16'(an), 16'hF);
    tick();
    chk_outs("reen.show", 4'hE, 2'd0, 4'hE, 1'b0, 1'b1);

    // Reset with a pending word: it must never reach the display.
    load_valid = 1'b1;
    load_data  = 16'h5555;
    tick();
    chk("pend.ready", 16'(load_ready), 16'd0);
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_outs("midreset", 4'hF, 2'd0, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    ok = 1'b1;
    while (cyc < 200) begin
      tick();
      if (digit_val != 4'h0) ok = 1'b0;
      if (cyc == 170) chk("postrst.an", 16'(an), 16'hE);
    end
    chk("postrst.val_zero", 16'(ok), 16'd1);

    // Load in IDLE: accepted, promoted next cycle; 0042 exercises leading-zero blanking.
    enable = 1'b0;
    tick();
    load_valid = 1'b1;
    load_data  = 16'h0042;
    tick();
    load_valid = 1'b0;
    chk("idle.accept.ready", 16'(load_ready), 16'd0);
    tick();
    chk("idle.promote.ready", 16'(load_ready), 16'd1);
    enable = 1'b1;
    tick();
    run_to(206);
    chk_outs("x42.d0", 4'hE, 2'd0, 4'h2, 1'b0, 1'b1);
    run_to(212);
    chk_outs("x42.d1", 4'hD, 2'd1, 4'h4, 1'b0, 1'b1);
    run_to(218);
    chk_outs("x42.d2", Lzb ? 4'hF : 4'hB, 2'd2, 4'h0, 1'b0, 1'b1);
    run_to(224);
    chk_outs("x42.d3", Lzb ? 4'hF : 4'h7, 2'd3, 4'h0, 1'b0, 1'b1);

    enable = 1'b0;
    tick();
    load_valid = 1'b1;
    load_data  = 16'h0000;
    tick();
    load_valid = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    run_to(230);
    chk_outs("x00.d0", 4'hE, 2'd0, 4'h0, 1'b0, 1'b1);
    run_to(236);
    chk_outs("x00.d1", Lzb ? 4'hF : 4'hD, 2'd1, 4'h0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
